// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift-register sequencer.
package shift_ctrl_pkg;

  // Sequencer states: one load cycle, N shift cycles, one done cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Shift direction encodings as seen on sr_dir.
  localparam logic DIR_MSB = 1'b0;  // ser_in enters bit 0, data moves toward MSB
  localparam logic DIR_LSB = 1'b1;  // ser_in enters bit WIDTH-1, data moves toward LSB

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_cnt.sv
// Loadable down-counter with zero flag; counts the remaining shift pulses.
module shift_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for an 8-bit load/shift register: one load cycle,
// then N shift pulses, then a one-cycle done pulse.
// Optional feature: define SHIFT_SEQ_ROTATE_EN to feed the bit leaving the
// register back into ser_in (rotate) instead of the command's fill bit.
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic             abort,
  input  logic [WIDTH-1:0] sr_q,
  output logic             sr_load,
  output logic             sr_shift,
  output logic             sr_dir,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_ser_in,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  state_e           state_q, state_d;
  logic             sr_load_q, sr_load_d;
  logic             sr_shift_q, sr_shift_d;
  logic             sr_dir_q, sr_dir_d;
  logic [WIDTH-1:0] sr_data_q, sr_data_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  logic             accept;
  logic [CNT_W-1:0] count_clamped;
  logic             fill_bit;

  assign accept        = cmd_valid && (state_q == IDLE);
  assign count_clamped = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;

`ifdef SHIFT_SEQ_ROTATE_EN
  // Fill bit is not used when rotating; the leaving bit re-enters instead.
  logic unused_fill;
  assign unused_fill = cmd_fill;
  assign fill_bit    = 1'b0;
  assign sr_ser_in   = (state_q == SHIFT) ? (sr_dir_q ? sr_q[0] : sr_q[WIDTH-1]) : 1'b0;
`else
  logic fill_q, fill_d;
  logic ser_in_q, ser_in_d;
  logic unused_sr_q;
  assign unused_sr_q = ^sr_q;
  assign fill_bit    = fill_q;
  assign sr_ser_in   = ser_in_q;

  // Captured fill bit and registered serial input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q   <= 1'b0;
      ser_in_q <= 1'b0;
    end else begin
      fill_q   <= fill_d;
      ser_in_q <= ser_in_d;
    end
  end

  // Fill is captured on accept; ser_in follows it only while shifting.
  always_comb begin
    fill_d   = accept ? cmd_fill : fill_q;
    ser_in_d = (state_d == SHIFT) ? fill_q : 1'b0;
  end
`endif

  shift_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  // Next state and registered strobes; strobes are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    sr_load_d    = 1'b0;
    sr_shift_d   = 1'b0;
    sr_dir_d     = sr_dir_q;
    sr_data_d    = sr_data_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = LOAD;
          sr_load_d    = 1'b1;
          sr_data_d    = cmd_data;
          sr_dir_d     = cmd_dir;
          cnt_load     = 1'b1;
          cnt_load_val = count_clamped;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          cnt_load  = 1'b1;
        end else if (cnt_zero) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = SHIFT;
          sr_shift_d = 1'b1;
        end
      end
      SHIFT: begin
        cnt_dec = 1'b1;
        if (abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          cnt_load  = 1'b1;
        end else if (cnt_val == CNT_W'(1)) begin
          // This cycle carries the last shift pulse.
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          sr_shift_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_load_q  <= 1'b0;
      sr_shift_q <= 1'b0;
      sr_dir_q   <= DIR_MSB;
      sr_data_q  <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_load_q  <= sr_load_d;
      sr_shift_q <= sr_shift_d;
      sr_dir_q   <= sr_dir_d;
      sr_data_q  <= sr_data_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sr_load   = sr_load_q;
  assign sr_shift  = sr_shift_q;
  assign sr_dir    = sr_dir_q;
  assign sr_data   = sr_data_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

  // fill_bit only carries meaning in the non-rotating build.
  logic unused_fill_bit;
  assign unused_fill_bit = fill_bit;

endmodule
